// File: rtl/lvds_rx_align_pkg.sv
// -----------------------------------------------------------------------------
// lvds_rx_align_pkg
// Shared definitions for the LVDS receive word aligner: lane FSM state
// encoding, default deserialisation factor, training word, lock threshold,
// and small counter helpers used by every lane.
// No ports (package).
// -----------------------------------------------------------------------------
package lvds_rx_align_pkg;

  localparam int unsigned DEF_FACTOR        = 8;
  localparam logic [7:0]  DEF_TRAIN_PATTERN = 8'h5C;
  localparam int unsigned DEF_LOCK_COUNT    = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } lane_state_t;

  // 4-bit increment that sticks at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    logic [3:0] r;
    if (v == 4'hF) begin
      r = v;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

  // Increment that wraps back to 0 after 'last'.
  function automatic logic [3:0] wrap_inc4(input logic [3:0] v, input logic [3:0] last);
    logic [3:0] r;
    if (v == last) begin
      r = 4'd0;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lvds_rx_align_lane.sv
// -----------------------------------------------------------------------------
// lvds_rx_align_lane
// One serial lane of the word aligner. Keeps a 2*FACTOR-bit history of the
// incoming bits, extracts the FACTOR-bit window at the current offset, and
// runs the SEARCH/VERIFY/LOCKED alignment FSM on word strobes.
//
// Ports
//   i_clk         clock, all logic on the rising edge
//   i_rst         synchronous active-high reset
//   i_bit         serial bit for this lane, sampled every edge
//   i_strobe      word strobe from the shared bit counter
//   i_align_req   restart alignment (wins over a coincident strobe)
//   o_window      FACTOR-bit window at the current offset, first bit = MSB
//   o_locked      registered: high exactly while the FSM is in LOCKED
//   o_slip_count  registered: offset slips since last restart, saturates at 15
// -----------------------------------------------------------------------------
module lvds_rx_align_lane
  import lvds_rx_align_pkg::*;
#(
  parameter int unsigned       FACTOR        = DEF_FACTOR,
  parameter logic [FACTOR-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter int unsigned       LOCK_COUNT    = DEF_LOCK_COUNT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_bit,
  input  logic              i_strobe,
  input  logic              i_align_req,
  output logic [FACTOR-1:0] o_window,
  output logic              o_locked,
  output logic [3:0]        o_slip_count
);

  logic [2*FACTOR-1:0] r_hist;
  logic [3:0]          r_offset;
  logic [3:0]          r_match_cnt;
  logic [3:0]          r_slip_cnt;
  logic                r_locked;
  lane_state_t         r_state;

  logic [2*FACTOR:0]   w_span;
  logic [FACTOR-1:0]   w_window;
  logic                w_match;
  logic [3:0]          w_offset_next;
  logic [3:0]          w_match_next;

  // The bit arriving on the strobe edge belongs to the word ending at that
  // strobe, so it is appended below the stored history; bit j of w_span was
  // sampled j cycles before the current edge. Offset k selects the FACTOR bits
  // ending k cycles back.
  assign w_span        = {r_hist, i_bit};
  assign w_window      = FACTOR'(w_span >> r_offset);
  assign w_match       = (w_window == TRAIN_PATTERN);
  assign w_offset_next = wrap_inc4(r_offset, 4'(FACTOR - 1));
  assign w_match_next  = r_match_cnt + 4'd1;

  // History shift plus alignment FSM; FSM only moves on strobes or restart.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hist      <= '0;
      r_offset    <= 4'd0;
      r_match_cnt <= 4'd0;
      r_slip_cnt  <= 4'd0;
      r_locked    <= 1'b0;
      r_state     <= ST_SEARCH;
    end else begin
      r_hist <= {r_hist[2*FACTOR-2:0], i_bit};
      if (i_align_req) begin
        r_offset    <= 4'd0;
        r_match_cnt <= 4'd0;
        r_slip_cnt  <= 4'd0;
        r_locked    <= 1'b0;
        r_state     <= ST_SEARCH;
      end else if (i_strobe) begin
        case (r_state)
          ST_SEARCH: begin
            if (w_match) begin
              r_match_cnt <= 4'd1;
              if (LOCK_COUNT == 32'd1) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end else begin
                r_state  <= ST_VERIFY;
                r_locked <= 1'b0;
              end
            end else begin
              r_offset   <= w_offset_next;
              r_slip_cnt <= sat_inc4(r_slip_cnt);
            end
          end
          ST_VERIFY: begin
            if (w_match) begin
              r_match_cnt <= w_match_next;
              if (w_match_next == 4'(LOCK_COUNT)) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end else begin
                r_state  <= ST_VERIFY;
                r_locked <= 1'b0;
              end
            end else begin
              // A failed verify is also a slip: the offset moves on.
              r_state     <= ST_SEARCH;
              r_match_cnt <= 4'd0;
              r_offset    <= w_offset_next;
              r_slip_cnt  <= sat_inc4(r_slip_cnt);
            end
          end
          ST_LOCKED: begin
            // Offset frozen; no pattern check until restart.
            r_state  <= ST_LOCKED;
            r_locked <= 1'b1;
          end
          default: begin
            r_state     <= ST_SEARCH;
            r_locked    <= 1'b0;
            r_match_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

  assign o_window     = w_window;
  assign o_locked     = r_locked;
  assign o_slip_count = r_slip_cnt;

endmodule

// File: rtl/lvds_rx_align.sv
// -----------------------------------------------------------------------------
// lvds_rx_align
// Multi-lane LVDS word aligner. A shared bit counter produces a word strobe
// every FACTOR cycles; each lane independently slides its word boundary until
// it sees LOCK_COUNT consecutive training words. Once every lane is locked,
// each strobe publishes all lane windows as one parallel word.
//
// Ports
//   clk_clk         clock, all logic on the rising edge
//   reset_reset     synchronous active-high reset
//   serial_data     one serial bit per lane
//   align_req       single-cycle request to restart alignment on all lanes
//   parallel_data   aligned words, lane c at [c*FACTOR +: FACTOR], held between pulses
//   parallel_valid  one-cycle strobe, one cycle after a strobe with all lanes locked
//   locked          per-lane lock status
//   slip_count      per-lane 4-bit saturating slip count
// -----------------------------------------------------------------------------
module lvds_rx_align
  import lvds_rx_align_pkg::*;
#(
  parameter int unsigned       CHANNELS      = 2,
  parameter int unsigned       FACTOR        = DEF_FACTOR,
  parameter logic [FACTOR-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter int unsigned       LOCK_COUNT    = DEF_LOCK_COUNT
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic [CHANNELS-1:0]          serial_data,
  input  logic                         align_req,
  output logic [CHANNELS*FACTOR-1:0]   parallel_data,
  output logic                         parallel_valid,
  output logic [CHANNELS-1:0]          locked,
  output logic [CHANNELS*4-1:0]        slip_count
);

  logic [3:0]                 r_bit_cnt;
  logic [CHANNELS*FACTOR-1:0] r_pdata;
  logic                       r_pvalid;

  logic                       w_strobe;
  logic [CHANNELS*FACTOR-1:0] w_windows;
  logic [CHANNELS-1:0]        w_locked;
  logic [CHANNELS*4-1:0]      w_slip;

  assign w_strobe = (r_bit_cnt == 4'(FACTOR - 1));

  // Shared bit counter; align_req deliberately does not touch it.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_bit_cnt <= 4'd0;
    end else begin
      r_bit_cnt <= wrap_inc4(r_bit_cnt, 4'(FACTOR - 1));
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    lvds_rx_align_lane #(
      .FACTOR        (FACTOR),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .LOCK_COUNT    (LOCK_COUNT)
    ) u_lane (
      .i_clk        (clk_clk),
      .i_rst        (reset_reset),
      .i_bit        (serial_data[c]),
      .i_strobe     (w_strobe),
      .i_align_req  (align_req),
      .o_window     (w_windows[c*FACTOR +: FACTOR]),
      .o_locked     (w_locked[c]),
      .o_slip_count (w_slip[c*4 +: 4])
    );
  end

  // Output word register: capture only on a strobe with every lane already
  // locked and no restart pending on that same edge.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_pdata  <= '0;
      r_pvalid <= 1'b0;
    end else if (w_strobe && !align_req && (&w_locked)) begin
      r_pdata  <= w_windows;
      r_pvalid <= 1'b1;
    end else begin
      r_pvalid <= 1'b0;
    end
  end

  assign parallel_data  = r_pdata;
  assign parallel_valid = r_pvalid;
  assign locked         = w_locked;
  assign slip_count     = w_slip;

endmodule

// File: tb/tb_lvds_rx_align.sv
// -----------------------------------------------------------------------------
// tb_lvds_rx_align
// Self-checking bench for lvds_rx_align (CHANNELS=2, FACTOR=8, pattern 8'h5C,
// LOCK_COUNT=4). A reference model built from stored bit history and a
// per-lane match streak predicts every output on every cycle; a table of
// alignment scenarios and a few hand-written sequences add end-state checks.
// -----------------------------------------------------------------------------
module tb_lvds_rx_align;

  localparam int         CH  = 2;
  localparam int         F   = 8;
  localparam int         LC  = 4;
  localparam logic [7:0] PAT = 8'h5C;

  logic        clk = 1'b0;
  logic        rst;
  logic        areq;
  logic [1:0]  sdata;
  logic [15:0] pdata;
  logic        pvalid;
  logic [1:0]  lck;
  logic [7:0]  slip;

  lvds_rx_align #(
    .CHANNELS      (2),
    .FACTOR        (8),
    .TRAIN_PATTERN (8'h5C),
    .LOCK_COUNT    (4)
  ) dut (
    .clk_clk        (clk),
    .reset_reset    (rst),
    .serial_data    (sdata),
    .align_req      (areq),
    .parallel_data  (pdata),
    .parallel_valid (pvalid),
    .locked         (lck),
    .slip_count     (slip)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: bits since reset, per-lane offset / streak / slips.
  bit          m_bits[CH][256];
  int          m_n;
  int          m_off[CH];
  int          m_streak[CH];
  int          m_slip[CH];
  bit          m_lock[CH];
  logic [15:0] m_pdata;
  bit          m_pvalid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Bit n of a repeating word w whose word boundary needs offset k.
  function automatic logic tbit(input logic [7:0] w, input int n, input int k);
    int p;
    p = (n + k) % 8;
    return w[7 - p];
  endfunction

  // Window of lane c ending k bits before the newest stored bit.
  function automatic logic [7:0] mwin(input int c, input int k);
    logic [7:0] w;
    int idx;
    w = 8'h00;
    for (int j = 0; j < F; j++) begin
      idx = m_n - 1 - k - (F - 1) + j;
      w = {w[6:0], (idx >= 0) ? m_bits[c][idx % 256] : 1'b0};
    end
    return w;
  endfunction

  task automatic model_edge(input bit r, input bit a, input logic [1:0] d);
    bit strobe, all_l;
    logic [7:0] w;
    if (r) begin
      m_n = 0;
      for (int c = 0; c < CH; c++) begin
        m_off[c] = 0; m_streak[c] = 0; m_slip[c] = 0; m_lock[c] = 1'b0;
      end
      m_pdata = 16'h0000;
      m_pvalid = 1'b0;
    end else begin
      strobe = ((m_n % F) == F - 1);
      all_l = 1'b1;
      for (int c = 0; c < CH; c++) all_l = all_l & m_lock[c];
      for (int c = 0; c < CH; c++) m_bits[c][m_n % 256] = d[c];
      m_n++;
      m_pvalid = 1'b0;
      if (a) begin
        for (int c = 0; c < CH; c++) begin
          m_off[c] = 0; m_streak[c] = 0; m_slip[c] = 0; m_lock[c] = 1'b0;
        end
      end else if (strobe) begin
        if (all_l) begin
          for (int c = 0; c < CH; c++) m_pdata[c*F +: F] = mwin(c, m_off[c]);
          m_pvalid = 1'b1;
        end
        for (int c = 0; c < CH; c++) begin
          if (!m_lock[c]) begin
            w = mwin(c, m_off[c]);
            if (w == PAT) begin
              m_streak[c]++;
              if (m_streak[c] >= LC) m_lock[c] = 1'b1;
            end else begin
              m_streak[c] = 0;
              m_off[c] = (m_off[c] + 1) % F;
              if (m_slip[c] < 15) m_slip[c]++;
            end
          end
        end
      end
    end
  endtask

  // One clock: drive, edge, advance model, compare all outputs 1 ns later.
  task automatic step(input bit r, input bit a, input logic [1:0] d);
    rst = r; areq = a; sdata = d;
    @(posedge clk);
    model_edge(r, a, d);
    #1;
    check("pdata",  32'(pdata),  32'(m_pdata));
    check("pvalid", 32'(pvalid), 32'(m_pvalid));
    check("locked", 32'(lck),    32'({m_lock[1], m_lock[0]}));
    check("slip",   32'(slip),   32'({4'(m_slip[1]), 4'(m_slip[0])}));
  endtask

  function automatic bit is_strobe_next();
    return ((m_n % F) == F - 1);
  endfunction

  // Reset, train, align_req on a strobe edge, then run ns strobes. Lane 1
  // needs offset k1 and is held at 0 for its first zs strobes after restart.
  task automatic run_row(input int k1, input int zs, input int ns);
    int seen;
    bit strobe;
    logic l1;
    step(1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, {tbit(PAT, m_n, k1), tbit(PAT, m_n, 0)});
    step(1'b0, 1'b1, {tbit(PAT, m_n, k1), tbit(PAT, m_n, 0)});
    seen = 0;
    while (seen < ns) begin
      strobe = is_strobe_next();
      l1 = (seen < zs) ? 1'b0 : tbit(PAT, m_n, k1);
      step(1'b0, 1'b0, {l1, tbit(PAT, m_n, 0)});
      if (strobe) seen++;
    end
  endtask

  typedef struct {
    int          k1;
    int          zs;
    int          ns;
    logic [7:0]  exp_slip;
    logic [1:0]  exp_lock;
    logic [15:0] exp_pdata;
  } row_t;

  row_t rows[5];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int seen, vpulses, pulses, last_cyc, cyc;
    bit strobe;
    logic l0;
    int k_r[CH];
    bit r, a;
    logic [1:0] d;

    // zero skew; lane 1 at offsets 3 and 7; lane 1 offset wraps once;
    // lane 1 never trains (slip saturates).
    rows[0] = '{k1: 0, zs: 0,    ns: 6,  exp_slip: 8'h00, exp_lock: 2'b11, exp_pdata: 16'h5C5C};
    rows[1] = '{k1: 3, zs: 0,    ns: 9,  exp_slip: 8'h30, exp_lock: 2'b11, exp_pdata: 16'h5C5C};
    rows[2] = '{k1: 7, zs: 0,    ns: 13, exp_slip: 8'h70, exp_lock: 2'b11, exp_pdata: 16'h5C5C};
    rows[3] = '{k1: 0, zs: 1,    ns: 14, exp_slip: 8'h80, exp_lock: 2'b11, exp_pdata: 16'h5C5C};
    rows[4] = '{k1: 0, zs: 1000, ns: 20, exp_slip: 8'hF0, exp_lock: 2'b01, exp_pdata: 16'h0000};

    rst = 1'b1; areq = 1'b0; sdata = 2'b00;
    step(1'b1, 1'b0, 2'b00);
    check("reset_pdata",  32'(pdata),  32'h0);
    check("reset_pvalid", 32'(pvalid), 32'h0);
    check("reset_locked", 32'(lck),    32'h0);
    check("reset_slip",   32'(slip),   32'h0);

    for (int i = 0; i < 5; i++) begin
      run_row(rows[i].k1, rows[i].zs, rows[i].ns);
      check("row_slip",  32'(slip),  32'(rows[i].exp_slip));
      check("row_lock",  32'(lck),   32'(rows[i].exp_lock));
      check("row_pdata", 32'(pdata), 32'(rows[i].exp_pdata));
    end
    // Row 0 ends on the first pulse after lock.
    run_row(0, 0, 5);
    check("first_valid", 32'(pvalid), 32'h1);

    // Glitch on the third verify strobe of lane 0.
    run_row(0, 0, 0);
    seen = 0; vpulses = 0;
    while (seen < 16) begin
      strobe = is_strobe_next();
      l0 = tbit(PAT, m_n, 0);
      if (strobe && seen == 3) l0 = ~l0;
      step(1'b0, 1'b0, {tbit(PAT, m_n, 0), l0});
      if (strobe) seen++;
      if (strobe && seen == 4) begin
        check("glitch_lock", 32'(lck),  32'h2);
        check("glitch_slip", 32'(slip), 32'h01);
      end
      if (seen < 16 && pvalid) vpulses++;
    end
    check("glitch_early_valid", 32'(vpulses), 32'h0);
    check("relock_valid", 32'(pvalid), 32'h1);
    check("relock_slip",  32'(slip),   32'h08);
    check("relock_lock",  32'(lck),    32'h3);
    check("relock_pdata", 32'(pdata),  32'h5C5C);

    // Locked stream of A1 / 3E, then align_req on a strobe edge.
    run_row(0, 0, 6);
    pulses = 0; last_cyc = -1;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b0, {tbit(8'h3E, m_n, 0), tbit(8'hA1, m_n, 0)});
      if (pvalid) begin
        pulses++;
        check("stream_pdata", 32'(pdata), 32'h3EA1);
        if (last_cyc >= 0) check("stream_gap", 32'(i - last_cyc), 32'd8);
        last_cyc = i;
      end
    end
    check("stream_pulses", 32'(pulses), 32'd3);
    while (!is_strobe_next()) step(1'b0, 1'b0, {tbit(8'h3E, m_n, 0), tbit(8'hA1, m_n, 0)});
    step(1'b0, 1'b1, {tbit(8'h3E, m_n, 0), tbit(8'hA1, m_n, 0)});
    check("areq_strobe_pvalid", 32'(pvalid), 32'h0);
    check("areq_strobe_locked", 32'(lck),    32'h0);

    // Reset on a strobe edge while locked, then relock as in row 0.
    run_row(0, 0, 6);
    while (!is_strobe_next()) step(1'b0, 1'b0, {tbit(PAT, m_n, 0), tbit(PAT, m_n, 0)});
    step(1'b1, 1'b0, {tbit(PAT, m_n, 0), tbit(PAT, m_n, 0)});
    check("lrst_pdata",  32'(pdata),  32'h0);
    check("lrst_pvalid", 32'(pvalid), 32'h0);
    check("lrst_locked", 32'(lck),    32'h0);
    check("lrst_slip",   32'(slip),   32'h0);
    run_row(rows[0].k1, rows[0].zs, rows[0].ns);
    check("lrst_relock_pdata", 32'(pdata), 32'(rows[0].exp_pdata));
    check("lrst_relock_lock",  32'(lck),   32'(rows[0].exp_lock));
    check("lrst_relock_slip",  32'(slip),  32'(rows[0].exp_slip));

    // Randomised run against the model: random skews, bit errors, restarts.
    k_r[0] = int'($urandom_range(0, 7));
    k_r[1] = int'($urandom_range(0, 7));
    step(1'b1, 1'b0, 2'b00);
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 699) == 0);
      a = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 299) == 0) begin
        k_r[0] = int'($urandom_range(0, 7));
        k_r[1] = int'($urandom_range(0, 7));
      end
      for (int c = 0; c < CH; c++) d[c] = tbit(PAT, m_n, k_r[c]) ^ ($urandom_range(0, 79) == 0);
      step(r, a, d);
      if (pvalid) cyc++;
    end
    check("random_saw_valid", 32'(cyc > 0), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lvds_rx_align.md
LVDS_RX_ALIGN -- requirements
Module: lvds_rx_align

Interface
REQ-001 Parameter CHANNELS, default 2, number of serial lanes.
REQ-002 Parameter FACTOR, default 8, deserialisation factor in bits per word; legal range 4..16.
REQ-003 Parameter TRAIN_PATTERN, default 8'h5C, FACTOR bits wide, per-lane training word.
REQ-004 Parameter LOCK_COUNT, default 4, consecutive training matches required for lock; legal range 1..15.
REQ-005 clk_clk  input  1  sole clock; one clock, all logic on its rising edge.
REQ-006 reset_reset  input  1  reset; reset is synchronous and active-high.
REQ-007 serial_data  input  CHANNELS  one bit per lane, sampled every clk_clk edge.
REQ-008 align_req  input  1  single-cycle request to restart alignment on all lanes.
REQ-009 parallel_data  output  CHANNELS*FACTOR  aligned words; lane c occupies bits [c*FACTOR +: FACTOR].
REQ-010 parallel_valid  output  1  one-cycle strobe marking a new parallel_data word.
REQ-011 locked  output  CHANNELS  per-lane lock status.
REQ-012 slip_count  output  CHANNELS*4  per-lane count of offset slips since the last restart, saturating at 15.

Function
REQ-013 A shared bit counter shall run 0..FACTOR-1 and wrap; word strobe = counter at FACTOR-1.
REQ-014 Each lane shall shift serial_data into a 2*FACTOR-bit history every cycle; the first-received bit is the word MSB.
REQ-015 On a strobe, the lane window at offset k (0..FACTOR-1) shall be the FACTOR bits sampled in cycles s-k-FACTOR+1..s-k, where s is the strobe cycle, inclusive.
REQ-016 Per-lane FSM states: SEARCH, VERIFY, LOCKED; the FSM shall evaluate only on strobes.
REQ-017 SEARCH: window == TRAIN_PATTERN moves to VERIFY with match count 1; a mismatch increments the offset and slip_count.
REQ-018 VERIFY: a match increments the match count and moves to LOCKED when the count reaches LOCK_COUNT; a mismatch returns to SEARCH, clears the count and increments the offset.
REQ-019 LOCK_COUNT=1 shall move SEARCH directly to LOCKED on the first match.
REQ-020 The offset shall wrap from FACTOR-1 to 0.
REQ-021 LOCKED shall hold the offset and stay there until align_req or reset; no pattern check is made in LOCKED.
REQ-022 locked[c] shall be 1 exactly when lane c is in LOCKED, registered from the state.
REQ-023 When all lanes are LOCKED on a strobe, parallel_data shall update with each lane's window and parallel_valid shall pulse in the cycle after the strobe (latency 1).
REQ-024 parallel_data shall hold its value between valid pulses; parallel_valid shall stay 0 while any lane is unlocked.
REQ-025 align_req shall force every lane to SEARCH on the next edge and clear the offset, match count and slip_count; the bit counter is not reset.
REQ-026 align_req coinciding with a strobe shall take priority over that strobe's evaluation, and no parallel_valid shall result from that strobe.

Reset
REQ-027 Synchronous reset shall set the following to 0: the bit counter, histories, offsets, match counts and slip_count.
REQ-028 Synchronous reset shall put all lane FSMs in SEARCH and set parallel_data=0, parallel_valid=0 and locked=0.
REQ-029 Reset asserted mid-alignment or mid-lock shall abort in one cycle, with no valid pulse in the cycle after the reset edge.

Structure
REQ-030 Package lvds_rx_align_pkg shall hold the lane FSM state enum and the default FACTOR, TRAIN_PATTERN and LOCK_COUNT constants.
REQ-031 Sub-module lvds_rx_align_lane shall implement one lane's history, offset, FSM and slip counter, instantiated CHANNELS times.
REQ-032 The top level shall hold the shared bit counter, the all-locked combine and the output registers.

Verification
REQ-033 Training 8'h5C on both lanes with zero skew, then align_req -> both lanes lock after 4 strobes, slip_count=0, parallel_data=16'h5C5C with parallel_valid.
REQ-034 Lane 1 delayed 3 bits relative to lane 0 -> lane 1 slip_count=3 and lane 0 slip_count=0; both locked, output 16'h5C5C.
REQ-035 Training glitch on the third VERIFY strobe -> that lane returns to SEARCH with offset+1, then re-locks after a further full cycle of slips, with no valid pulse until locked.
REQ-036 Lane required offset 7 with FACTOR=8 -> offset wraps to 0 on the eighth slip; slip_count is 15 after 16 mismatches and stays at 15.
REQ-037 Locked, data 0xA1/0x3E streaming -> valid every 8 cycles carrying 16'h3EA1; align_req on a strobe cycle -> no pulse from that strobe, and locked=0 next cycle.
REQ-038 Reset asserted while LOCKED -> all outputs 0 next cycle; relock after release is identical to REQ-033.
